im_loader: RTL

Boot-time instruction-memory writer for the MIPS core. It accepts a framed byte stream, assembles big-endian 32-bit words and writes them into the instruction memory's write port at the main-code base or the exception-handler base. It holds the CPU in reset until a release command arrives, and it reports the end-of-program PC the fetch stage uses to stop simulation.

---
 rtl/im_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Frames a byte stream into big-endian words and holds the core in reset.
module im_loader #(
   parameter logic [31:0] PC_BEGIN      = 32'h0000_3000,
   parameter logic [31:0] PC_END        = 32'h0000_4ffc,
   parameter logic [31:0] HANDLER_BEGIN = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   output logic        cpu_reset,
   output logic [31:0] end_pc,
   output logic        err
);

   typedef enum logic [2:0] {
      S_CMD,
      S_CNT_HI,
      S_CNT_LO,
      S_DATA,
      S_DONE
   } state_t;

   localparam logic [7:0] CMD_MAIN = 8'hA5;
   localparam logic [7:0] CMD_HNDL = 8'h5A;
   localparam logic [7:0] CMD_REL  = 8'h0F;

   state_t      state_q, state_d;
   logic [31:0] wa_q, wa_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  bc_q, bc_d;
   logic [23:0] word_q, word_d;
   logic        main_q, main_d;
   logic [31:0] end_pc_q, end_pc_d;
   logic        err_q, err_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        fire;
   logic [15:0] n_cnt;
   logic [31:0] full_word;

   assign in_ready  = (state_q != S_DONE);
   assign cpu_reset = (state_q != S_DONE);
   assign fire      = in_valid & in_ready;
   assign n_cnt     = {cnt_q[15:8], in_data};
   assign full_word = {word_q, in_data};

   always_comb begin
      state_d  = state_q;
      wa_d     = wa_q;
      cnt_d    = cnt_q;
      bc_d     = bc_q;
      word_d   = word_q;
      main_d   = main_q;
      end_pc_d = end_pc_q;
      err_d    = err_q;
      we_d     = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      unique case (state_q)
         S_CMD: begin
            if (fire) begin
               if (in_data == CMD_MAIN) begin
                  wa_d    = PC_BEGIN;
                  main_d  = 1'b1;
                  state_d = S_CNT_HI;
               end else if (in_data == CMD_HNDL) begin
                  wa_d    = HANDLER_BEGIN;
                  main_d  = 1'b0;
                  state_d = S_CNT_HI;
               end else if (in_data == CMD_REL) begin
                  state_d = S_DONE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_CNT_HI: begin
            if (fire) begin
               cnt_d   = {in_data, 8'h00};
               state_d = S_CNT_LO;
            end
         end
         S_CNT_LO: begin
            if (fire) begin
               cnt_d = n_cnt;
               bc_d  = 2'd0;
               if (main_q) begin
                  end_pc_d = PC_BEGIN + ((32'(n_cnt) + 32'd6) << 2);
               end
               state_d = (n_cnt == 16'd0) ? S_CMD : S_DATA;
            end
         end
         S_DATA: begin
            if (fire) begin
               bc_d = bc_q + 2'd1;
               if (bc_q == 2'd3) begin
                  // out-of-range words are dropped but keep the stream in sync
                  if (wa_q > PC_END) begin
                     err_d = 1'b1;
                  end else begin
                     we_d    = 1'b1;
                     addr_d  = wa_q;
                     wdata_d = full_word;
                  end
                  wa_d  = wa_q + 32'd4;
                  cnt_d = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     state_d = S_CMD;
                  end
               end else begin
                  word_d = full_word[23:0];
               end
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_CMD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_CMD;
         wa_q     <= 32'd0;
         cnt_q    <= 16'd0;
         bc_q     <= 2'd0;
         word_q   <= 24'd0;
         main_q   <= 1'b0;
         end_pc_q <= PC_BEGIN + 32'd24;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         wa_q     <= wa_d;
         cnt_q    <= cnt_d;
         bc_q     <= bc_d;
         word_q   <= word_d;
         main_q   <= main_d;
         end_pc_q <= end_pc_d;
         err_q    <= err_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign im_we    = we_q;
   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;
   assign end_pc   = end_pc_q;
   assign err      = err_q;

endmodule
